// File: rtl/fsb_pkg.sv
// Shared types, termination priority and default timing for the FSB cycle terminator.
package fsb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, TERM} state_e;

    typedef enum logic [1:0] {TERM_NONE, TERM_DTACK, TERM_VPA, TERM_BERR} term_e;

    // Bit positions in the termination request vector; a higher index wins.
    localparam int unsigned PRIO_TIMEOUT = 0;
    localparam int unsigned PRIO_DTACK   = 1;
    localparam int unsigned PRIO_VPA     = 2;
    localparam int unsigned PRIO_DECODE  = 3;
    localparam int unsigned PRIO_NUM     = 4;

    localparam int TO_LIMIT_DEF = 200;
    localparam int IACK_DLY_DEF = 2;

    function automatic term_e pick_term(input logic [PRIO_NUM-1:0] req);
        term_e t;
        t = TERM_NONE;
        if (req[PRIO_TIMEOUT]) t = TERM_BERR;
        if (req[PRIO_DTACK])   t = TERM_DTACK;
        if (req[PRIO_VPA])     t = TERM_VPA;
        if (req[PRIO_DECODE])  t = TERM_BERR;
        return t;
    endfunction

endpackage

// File: rtl/fsb_watchdog.sv
// Saturating bus watchdog: counts FCLK cycles while enabled, flags the timeout cycle.
module fsb_watchdog #(
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [TO_W-1:0] count,
    output logic            tc
);

    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] TC_VAL  = TO_W'(TO_LIMIT - 1);

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == TC_VAL);

endmodule

// File: rtl/fsb_cycle_term.sv
// MC68HC000 FSB cycle terminator: picks one ready source per /AS cycle and drives
// registered /DTACK, /VPA or /BERR, plus a saturating bus-error event counter.
module fsb_cycle_term
    import fsb_pkg::*;
#(
    parameter int NSRC     = 4,
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = TO_LIMIT_DEF,
    parameter int IACK_DLY = IACK_DLY_DEF,
    parameter int ERR_W    = 4
) (
    input  logic             FCLK,
    input  logic             RES,
    input  logic             nAS_FSB,
    input  logic [NSRC-1:0]  SEL,
    input  logic [NSRC-1:0]  RDY,
    input  logic             IACS,
    input  logic             QoSReady,
    output logic             nDTACK_FSB,
    output logic             nVPA_FSB,
    output logic             nBERR_FSB,
    output logic             BACT,
    output logic             BACTr,
    output logic [ERR_W-1:0] ERRCNT
);

    localparam logic [TO_W-1:0]  IACK_CNT = (IACK_DLY > 1) ? TO_W'(IACK_DLY - 1) : '0;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e               state_q, state_d;
    logic                 ndtack_q, ndtack_d;
    logic                 nvpa_q, nvpa_d;
    logic                 nberr_q, nberr_d;
    logic                 bactr_q;
    logic [ERR_W-1:0]     errcnt_q, errcnt_d;
    logic [TO_W-1:0]      wd_count;
    logic                 wd_tc;
    logic                 dec_err;
    logic [PRIO_NUM-1:0]  req;
    term_e                term;

    assign BACT = ~nAS_FSB;

    // More than one select bit, or a device select during interrupt acknowledge.
    assign dec_err = ((SEL & (SEL - 1'b1)) != '0) || ((|SEL) && IACS);

    always_comb begin
        req               = '0;
        req[PRIO_DECODE]  = dec_err;
        req[PRIO_VPA]     = IACS && (wd_count >= IACK_CNT);
        req[PRIO_DTACK]   = (|(SEL & RDY)) && QoSReady;
        req[PRIO_TIMEOUT] = wd_tc;
    end

    assign term = pick_term(req);

    fsb_watchdog #(
        .TO_W     (TO_W),
        .TO_LIMIT (TO_LIMIT)
    ) u_watchdog (
        .clk   (FCLK),
        .rst   (RES),
        .clr   (state_q != RUN),
        .en    (state_q == RUN),
        .count (wd_count),
        .tc    (wd_tc)
    );

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        ndtack_d = ndtack_q;
        nvpa_d   = nvpa_q;
        nberr_d  = nberr_q;
        errcnt_d = errcnt_q;
        unique case (state_q)
            IDLE: begin
                if (BACT) state_d = RUN;
            end
            RUN: begin
                if (!BACT) begin
                    state_d = IDLE;
                end else if (term != TERM_NONE) begin
                    state_d  = TERM;
                    ndtack_d = (term != TERM_DTACK);
                    nvpa_d   = (term != TERM_VPA);
                    nberr_d  = (term != TERM_BERR);
                    if ((term == TERM_BERR) && (errcnt_q != ERR_MAX)) begin
                        errcnt_d = errcnt_q + 1'b1;
                    end
                end
            end
            TERM: begin
                if (nAS_FSB) begin
                    state_d  = IDLE;
                    ndtack_d = 1'b1;
                    nvpa_d   = 1'b1;
                    nberr_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ndtack_d = 1'b1;
                nvpa_d   = 1'b1;
                nberr_d  = 1'b1;
            end
        endcase
    end

    // NOTE: asynchronous reset puts every strobe back to its inactive level at once,
    // even in the middle of a bus cycle.
    always_ff @(posedge FCLK or posedge RES) begin
        if (RES) begin
            state_q  <= IDLE;
            ndtack_q <= 1'b1;
            nvpa_q   <= 1'b1;
            nberr_q  <= 1'b1;
            bactr_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q  <= state_d;
            ndtack_q <= ndtack_d;
            nvpa_q   <= nvpa_d;
            nberr_q  <= nberr_d;
            bactr_q  <= BACT;
            errcnt_q <= errcnt_d;
        end
    end

    assign nDTACK_FSB = ndtack_q;
    assign nVPA_FSB   = nvpa_q;
    assign nBERR_FSB  = nberr_q;
    assign BACTr      = bactr_q;
    assign ERRCNT     = errcnt_q;

endmodule

// File: tb/tb_fsb_cycle_term.sv
// Randomised bench for fsb_cycle_term: each bus cycle's termination edge and strobe
// are predicted from the cycle-level rules before the cycle is driven.
module tb_fsb_cycle_term;

    localparam int NSRC     = 4;
    localparam int TO_W     = 8;
    localparam int TO_LIMIT = 200;
    localparam int IACK_DLY = 2;
    localparam int ERR_W    = 4;
    localparam int ERR_MAX  = 2**ERR_W - 1;
    localparam int NEVER    = 100000;

    logic             FCLK = 1'b0;
    logic             RES;
    logic             nAS_FSB;
    logic [NSRC-1:0]  SEL;
    logic [NSRC-1:0]  RDY;
    logic             IACS;
    logic             QoSReady;
    logic             nDTACK_FSB;
    logic             nVPA_FSB;
    logic             nBERR_FSB;
    logic             BACT;
    logic             BACTr;
    logic [ERR_W-1:0] ERRCNT;
    logic [2:0]       strobes;

    int n_checks = 0;
    int n_pass   = 0;
    int err_model = 0;

    always #5 FCLK = ~FCLK;

    assign strobes = {nDTACK_FSB, nVPA_FSB, nBERR_FSB};

    fsb_cycle_term #(
        .NSRC     (NSRC),
        .TO_W     (TO_W),
        .TO_LIMIT (TO_LIMIT),
        .IACK_DLY (IACK_DLY),
        .ERR_W    (ERR_W)
    ) dut (
        .FCLK       (FCLK),
        .RES        (RES),
        .nAS_FSB    (nAS_FSB),
        .SEL        (SEL),
        .RDY        (RDY),
        .IACS       (IACS),
        .QoSReady   (QoSReady),
        .nDTACK_FSB (nDTACK_FSB),
        .nVPA_FSB   (nVPA_FSB),
        .nBERR_FSB  (nBERR_FSB),
        .BACT       (BACT),
        .BACTr      (BACTr),
        .ERRCNT     (ERRCNT)
    );

    task automatic step();
        @(posedge FCLK);
        #1;
    endtask

    // One complete /AS cycle. rdy_at/qos_at: first RUN edge index at which the
    // selected RDY bit / QoSReady is sampled high; hold: extra edges with /AS low.
    task automatic drive_cycle(input logic [NSRC-1:0] sel, input logic iacs,
                               input int rdy_at, input int qos_at, input int hold,
                               input string tag);
        int         k;
        int         m;
        logic [2:0] low_vec;
        logic [2:0] exp;
        m = (rdy_at > qos_at) ? rdy_at : qos_at;
        if (m < 1) m = 1;
        if (($countones(sel) > 1) || ((sel != '0) && iacs)) begin
            k = 1;
            low_vec = 3'b110;
        end else if (iacs) begin
            k = (IACK_DLY > 1) ? IACK_DLY : 1;
            low_vec = 3'b101;
        end else if ((sel != '0) && (m <= TO_LIMIT)) begin
            k = m;
            low_vec = 3'b011;
        end else begin
            k = TO_LIMIT;
            low_vec = 3'b110;
        end

        nAS_FSB  = 1'b0;
        SEL      = sel;
        IACS     = iacs;
        QoSReady = 1'b0;
        RDY      = NSRC'($urandom) & ~sel;
        step();
        n_checks++;
        if (strobes !== 3'b111)
            $display("FAIL %s accept strobes: got %b want 111", tag, strobes);
        else n_pass++;

        for (int j = 1; j <= k + hold; j++) begin
            RDY      = (NSRC'($urandom) & ~sel) | ((j >= rdy_at) ? sel : '0);
            QoSReady = (j >= qos_at);
            step();
            if ((j == k) && (low_vec == 3'b110) && (err_model < ERR_MAX)) err_model++;
            exp = (j >= k) ? low_vec : 3'b111;
            n_checks++;
            if (strobes !== exp)
                $display("FAIL %s strobes edge %0d: got %b want %b", tag, j, strobes, exp);
            else n_pass++;
            n_checks++;
            if (ERRCNT !== ERR_W'(err_model))
                $display("FAIL %s errcnt edge %0d: got %0d want %0d", tag, j, ERRCNT, err_model);
            else n_pass++;
            n_checks++;
            if (BACTr !== 1'b1)
                $display("FAIL %s bactr edge %0d: got %b want 1", tag, j, BACTr);
            else n_pass++;
        end

        nAS_FSB = 1'b1;
        SEL     = '0;
        IACS    = 1'b0;
        RDY     = NSRC'($urandom);
        step();
        n_checks++;
        if (strobes !== 3'b111)
            $display("FAIL %s release strobes: got %b want 111", tag, strobes);
        else n_pass++;
        n_checks++;
        if (BACTr !== 1'b0)
            $display("FAIL %s release bactr: got %b want 0", tag, BACTr);
        else n_pass++;
    endtask

    task automatic test_reset();
        RES      = 1'b1;
        nAS_FSB  = 1'b1;
        SEL      = '0;
        RDY      = '0;
        IACS     = 1'b0;
        QoSReady = 1'b0;
        #1;
        n_checks++;
        if ({strobes, BACTr, ERRCNT} !== {3'b111, 1'b0, 4'd0})
            $display("FAIL reset_values: got %b/%b/%0d want 111/0/0", strobes, BACTr, ERRCNT);
        else n_pass++;
        nAS_FSB = 1'b0;
        #1;
        n_checks++;
        if (BACT !== 1'b1) $display("FAIL bact_comb: got %b want 1", BACT);
        else n_pass++;
        nAS_FSB = 1'b1;
        #1;
        n_checks++;
        if (BACT !== 1'b0) $display("FAIL bact_comb_idle: got %b want 0", BACT);
        else n_pass++;
        repeat (2) @(posedge FCLK);
        @(negedge FCLK);
        RES = 1'b0;
        err_model = 0;
    endtask

    task automatic test_ram_read();
        drive_cycle(4'b0001, 1'b0, 3, 0, 2, "ram_read");
    endtask

    task automatic test_iack();
        drive_cycle(4'b0000, 1'b1, NEVER, 0, 1, "iack");
    endtask

    task automatic test_timeout();
        drive_cycle(4'b0000, 1'b0, NEVER, 0, 1, "timeout");
        n_checks++;
        if (ERRCNT !== 4'd1) $display("FAIL timeout_errcnt: got %0d want 1", ERRCNT);
        else n_pass++;
    endtask

    task automatic test_qos_stall();
        drive_cycle(4'b0010, 1'b0, 1, 11, 1, "qos_stall");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            int r;
            int i1;
            int i2;
            r  = $urandom_range(0, 9);
            i1 = $urandom_range(0, NSRC - 1);
            i2 = (i1 + 1 + $urandom_range(0, NSRC - 2)) % NSRC;
            case (r)
                0: drive_cycle(NSRC'((1 << i1) | (1 << i2)), 1'b0, 0, 0,
                               $urandom_range(0, 3), "rand_decode");
                1: drive_cycle(NSRC'(1 << i1), 1'b1, 0, 0, $urandom_range(0, 3), "rand_iack_sel");
                2: drive_cycle('0, 1'b1, NEVER, 0, $urandom_range(0, 3), "rand_iack");
                3: if ($urandom_range(0, 3) == 0)
                       drive_cycle('0, 1'b0, NEVER, 0, $urandom_range(0, 3), "rand_timeout");
                   else
                       drive_cycle(NSRC'(1 << i1), 1'b0, 1, 1, 0, "rand_fast");
                default: drive_cycle(NSRC'(1 << i1), 1'b0, $urandom_range(1, 12),
                                     $urandom_range(0, 12), $urandom_range(0, 3), "rand_dtack");
            endcase
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                step();
                n_checks++;
                if (strobes !== 3'b111) $display("FAIL idle_gap strobes: got %b want 111", strobes);
                else n_pass++;
            end
        end
    endtask

    task automatic test_decode_saturate();
        for (int n = 0; n < 20; n++) drive_cycle(4'b0101, 1'b0, 0, 0, 0, "decode");
        n_checks++;
        if (ERRCNT !== 4'd15) $display("FAIL errcnt_saturate: got %0d want 15", ERRCNT);
        else n_pass++;
    endtask

    task automatic test_abort();
        nAS_FSB  = 1'b0;
        SEL      = 4'b0001;
        IACS     = 1'b0;
        QoSReady = 1'b1;
        for (int j = 0; j <= 150; j++) begin
            RDY = NSRC'($urandom) & 4'b1110;
            step();
            n_checks++;
            if (strobes !== 3'b111) $display("FAIL abort_run edge %0d: got %b want 111", j, strobes);
            else n_pass++;
        end
        nAS_FSB = 1'b1;
        SEL     = '0;
        step();
        n_checks++;
        if ({strobes, ERRCNT} !== {3'b111, ERR_W'(err_model)})
            $display("FAIL abort_exit: got %b/%0d want 111/%0d", strobes, ERRCNT, err_model);
        else n_pass++;
        drive_cycle('0, 1'b0, NEVER, 0, 0, "post_abort_timeout");
    endtask

    task automatic test_reset_mid_cycle();
        nAS_FSB  = 1'b0;
        SEL      = 4'b0100;
        RDY      = 4'b0100;
        IACS     = 1'b0;
        QoSReady = 1'b1;
        step();
        step();
        n_checks++;
        if (strobes !== 3'b011) $display("FAIL pre_reset_dtack: got %b want 011", strobes);
        else n_pass++;
        #2;
        RES = 1'b1;
        #1;
        err_model = 0;
        n_checks++;
        if ({strobes, BACTr, ERRCNT} !== {3'b111, 1'b0, 4'd0})
            $display("FAIL mid_reset: got %b/%b/%0d want 111/0/0", strobes, BACTr, ERRCNT);
        else n_pass++;
        @(negedge FCLK);
        nAS_FSB = 1'b1;
        SEL     = '0;
        RDY     = '0;
        @(negedge FCLK);
        RES = 1'b0;
        drive_cycle(4'b0010, 1'b0, 2, 0, 1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_iack();
        test_timeout();
        test_qos_stall();
        test_back_to_back();
        test_decode_saturate();
        test_abort();
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
